// File: rtl/puf_pkg.sv
// Shared types and defaults for the race PUF sequencer.
package puf_pkg;

  localparam int unsigned RESP_BITS_DEF = 16;
  localparam int unsigned VOTES_DEF     = 5;
  localparam int unsigned SETTLE_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned CH_W_DEF      = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_SAMPLE,
    S_RESOLVE,
    S_DONE
  } race_seq_state_t;

  // A bit resolves to 1 when strictly more than this many votes were 1.
  function automatic int unsigned maj_thresh(input int unsigned votes);
    return votes / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/race_puf_sequencer.sv
// Drives one race arbiter through VOTES evaluations per response bit and
// majority-decodes the result, flagging unstable bits and timed-out votes.
module race_puf_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned RESP_BITS = RESP_BITS_DEF,
  parameter int unsigned VOTES     = VOTES_DEF,
  parameter int unsigned SETTLE    = SETTLE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned CH_W      = CH_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CH_W-1:0]      chal_base,
  output logic                 busy,
  output logic [CH_W-1:0]      chal_out,
  output logic                 arb_reset,
  output logic                 launch,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic [RESP_BITS-1:0] resp,
  output logic [RESP_BITS-1:0] unstable,
  output logic                 timeout_err,
  output logic                 resp_valid
);

  localparam int unsigned VW  = $clog2(VOTES + 1);
  localparam int unsigned WW  = $clog2(TIMEOUT + 1);
  localparam int unsigned BW  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned SW  = $clog2(SETTLE + 1);
  localparam int unsigned THR = maj_thresh(VOTES);

  race_seq_state_t r_state;
  race_seq_state_t w_state_nxt;

  logic                 w_done_s;
  logic                 w_out_s;
  logic                 w_vote_last;
  logic                 w_bit_last;
  logic                 w_arb_reset_nxt;
  logic                 w_busy_nxt;
  logic                 w_launch_nxt;
  logic                 w_valid_nxt;

  logic [CH_W-1:0]      r_chal_base;
  logic [CH_W-1:0]      r_chal_out;
  logic [BW-1:0]        r_bit_idx;
  logic [VW-1:0]        r_vote_idx;
  logic [VW-1:0]        r_ones_cnt;
  logic [WW-1:0]        r_wait_cnt;
  logic [SW-1:0]        r_settle_cnt;
  logic                 r_vote_tmo;
  logic                 r_tmo_bit;
  logic [RESP_BITS-1:0] r_resp;
  logic [RESP_BITS-1:0] r_unstable;
  logic                 r_timeout_err;
  logic                 r_busy;
  logic                 r_arb_reset;
  logic                 r_launch;
  logic                 r_resp_valid;

  sync_2ff u_sync_done (
    .clk   (clk),
    .reset (reset),
    .i_d   (arb_done),
    .o_q   (w_done_s)
  );

  sync_2ff u_sync_out (
    .clk   (clk),
    .reset (reset),
    .i_d   (arb_out),
    .o_q   (w_out_s)
  );

  assign w_vote_last = (r_vote_idx == VW'(VOTES - 1));
  assign w_bit_last  = (r_bit_idx == BW'(RESP_BITS - 1));

  // Next state; registered outputs are derived from the state being entered.
  always_comb begin
    w_state_nxt     = r_state;
    w_arb_reset_nxt = 1'b1;
    w_busy_nxt      = 1'b1;
    w_launch_nxt    = 1'b0;
    w_valid_nxt     = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CLEAR;
      S_CLEAR:   if (r_settle_cnt == SW'(SETTLE - 1)) w_state_nxt = S_LAUNCH;
      S_LAUNCH:  w_state_nxt = S_WAIT;
      S_WAIT:    if (w_done_s || (r_wait_cnt == WW'(TIMEOUT - 1))) w_state_nxt = S_SAMPLE;
      S_SAMPLE:  w_state_nxt = w_vote_last ? S_RESOLVE : S_CLEAR;
      S_RESOLVE: w_state_nxt = w_bit_last ? S_DONE : S_CLEAR;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_IDLE:                     w_busy_nxt      = 1'b0;
      S_LAUNCH:                   begin
                                    w_arb_reset_nxt = 1'b0;
                                    w_launch_nxt    = 1'b1;
                                  end
      S_WAIT, S_SAMPLE:           w_arb_reset_nxt = 1'b0;
      S_DONE:                     w_valid_nxt     = 1'b1;
      default:                    w_busy_nxt      = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_chal_base   <= '0;
      r_chal_out    <= '0;
      r_bit_idx     <= '0;
      r_vote_idx    <= '0;
      r_ones_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_settle_cnt  <= '0;
      r_vote_tmo    <= 1'b0;
      r_tmo_bit     <= 1'b0;
      r_resp        <= '0;
      r_unstable    <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_arb_reset   <= 1'b1;
      r_launch      <= 1'b0;
      r_resp_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= w_busy_nxt;
      r_arb_reset  <= w_arb_reset_nxt;
      r_launch     <= w_launch_nxt;
      r_resp_valid <= w_valid_nxt;
      r_settle_cnt <= (r_state == S_CLEAR) ? r_settle_cnt + SW'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal_base   <= chal_base;
            r_chal_out    <= chal_base;
            r_bit_idx     <= '0;
            r_vote_idx    <= '0;
            r_ones_cnt    <= '0;
            r_tmo_bit     <= 1'b0;
            r_resp        <= '0;
            r_unstable    <= '0;
            r_timeout_err <= 1'b0;
          end
        end
        S_LAUNCH: r_wait_cnt <= '0;
        S_WAIT: begin
          // Holds on exit: 1 only when leaving through the timeout.
          r_vote_tmo <= ~w_done_s;
          if (!w_done_s && (r_wait_cnt != WW'(TIMEOUT - 1))) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        S_SAMPLE: begin
          if (r_vote_tmo) begin
            r_timeout_err <= 1'b1;
            r_tmo_bit     <= 1'b1;
          end else begin
            r_ones_cnt <= r_ones_cnt + VW'(w_out_s);
          end
          r_vote_idx <= r_vote_idx + VW'(1);
        end
        S_RESOLVE: begin
          r_resp[r_bit_idx]     <= (r_ones_cnt > VW'(THR));
          r_unstable[r_bit_idx] <= ((r_ones_cnt != '0) && (r_ones_cnt != VW'(VOTES))) || r_tmo_bit;
          r_ones_cnt            <= '0;
          r_vote_idx            <= '0;
          r_tmo_bit             <= 1'b0;
          if (!w_bit_last) begin
            r_bit_idx  <= r_bit_idx + BW'(1);
            r_chal_out <= r_chal_base + CH_W'(r_bit_idx) + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign chal_out    = r_chal_out;
  assign arb_reset   = r_arb_reset;
  assign launch      = r_launch;
  assign resp        = r_resp;
  assign unstable    = r_unstable;
  assign timeout_err = r_timeout_err;
  assign resp_valid  = r_resp_valid;

endmodule

// File: tb/tb_race_puf_sequencer.sv
// Directed bench for race_puf_sequencer with a behavioural arbiter and a
// scoreboard of per-launch and per-run expectations.
module tb_race_puf_sequencer;

  localparam int RB = 4;
  localparam int V  = 3;
  localparam int ST = 2;
  localparam int TO = 16;
  localparam int K  = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] chal_base;
  logic          busy;
  logic [CW-1:0] chal_out;
  logic          arb_reset;
  logic          launch;
  logic          arb_done;
  logic          arb_out;
  logic [RB-1:0] resp;
  logic [RB-1:0] unstable;
  logic          timeout_err;
  logic          resp_valid;

  race_puf_sequencer #(
    .RESP_BITS (RB),
    .VOTES     (V),
    .SETTLE    (ST),
    .TIMEOUT   (TO),
    .CH_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .chal_base   (chal_base),
    .busy        (busy),
    .chal_out    (chal_out),
    .arb_reset   (arb_reset),
    .launch      (launch),
    .arb_done    (arb_done),
    .arb_out     (arb_out),
    .resp        (resp),
    .unstable    (unstable),
    .timeout_err (timeout_err),
    .resp_valid  (resp_valid)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural arbiter: done rises K cycles after the launch pulse is seen.
  logic tab_val [RB][V];
  logic tab_tmo [RB][V];
  int   m_cnt      = 0;
  int   m_launches = 0;
  logic m_val      = 1'b0;
  logic m_tmo      = 1'b0;

  always @(posedge clk) begin
    if (!busy) m_launches <= 0;
    if (arb_reset) begin
      m_cnt <= 0;
    end else if (launch) begin
      m_cnt <= 1;
      if (m_launches < RB * V) begin
        m_val <= tab_val[m_launches / V][m_launches % V];
        m_tmo <= tab_tmo[m_launches / V][m_launches % V];
      end
      m_launches <= m_launches + 1;
    end else if (m_cnt != 0 && m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
    end
  end

  // A hung race leaves out stuck at 1 so a timed-out vote must not count it.
  assign arb_done = !m_tmo && (m_cnt >= K);
  assign arb_out  = m_tmo ? 1'b1 : ((m_cnt >= K) ? m_val : 1'b0);

  typedef struct {
    logic [RB-1:0] resp;
    logic [RB-1:0] unstable;
    logic          tmo;
    int            lat;
  } run_exp_t;

  run_exp_t      exp_run[$];
  logic [CW-1:0] exp_chal[$];
  int            exp_gap[$];

  int            ncyc      = 0;
  int            acc_cyc   = 0;
  int            prev_l    = 0;
  int            n_launch  = 0;
  int            n_valid   = 0;
  int            hi_run    = 0;
  int            chal_run  = 0;
  logic [CW-1:0] chal_prev = '0;

  always @(negedge clk) begin
    int stable_before;
    ncyc++;
    stable_before = (chal_out == chal_prev) ? chal_run : 0;
    if (reset) begin
      exp_run.delete();
      exp_chal.delete();
      exp_gap.delete();
      hi_run = 0;
    end else begin
      if (start && !busy) begin
        acc_cyc  = ncyc;
        prev_l   = ncyc;
        n_launch = 0;
      end
      if (launch) begin
        n_launch++;
        check("arb_reset_settle", 32'(hi_run >= ST), 32'd1);
        check("arb_reset_in_launch", 32'(arb_reset), 32'd0);
        check("chal_stable_before_launch", 32'(stable_before >= ST), 32'd1);
        check("launch_expected", 32'(exp_chal.size() != 0), 32'd1);
        if (exp_chal.size() != 0) check("chal_out", chal_out, exp_chal.pop_front());
        if (exp_gap.size() != 0) check("launch_gap", 32'(ncyc - prev_l), 32'(exp_gap.pop_front()));
        prev_l = ncyc;
      end
      if (resp_valid) begin
        n_valid++;
        check("resp_valid_expected", 32'(exp_run.size() != 0), 32'd1);
        if (exp_run.size() != 0) begin
          run_exp_t e;
          e = exp_run.pop_front();
          check("resp", 32'(resp), 32'(e.resp));
          check("unstable", 32'(unstable), 32'(e.unstable));
          check("timeout_err", 32'(timeout_err), 32'(e.tmo));
          check("latency", 32'(ncyc - acc_cyc), 32'(e.lat));
          check("launch_count", 32'(n_launch), 32'(RB * V));
          check("busy_in_done", 32'(busy), 32'd1);
        end
      end
      hi_run = arb_reset ? hi_run + 1 : 0;
    end
    chal_run  = (chal_out == chal_prev) ? chal_run + 1 : 1;
    chal_prev = chal_out;
  end

  task automatic set_bit(input int b, input logic v0, input logic v1, input logic v2,
                         input logic t2);
    tab_val[b][0] = v0; tab_val[b][1] = v1; tab_val[b][2] = v2;
    tab_tmo[b][0] = 1'b0; tab_tmo[b][1] = 1'b0; tab_tmo[b][2] = t2;
  endtask

  task automatic push_expect(input logic [CW-1:0] base);
    run_exp_t e;
    int ones, gap, vl;
    logic t;
    e.resp = '0; e.unstable = '0; e.tmo = 1'b0;
    e.lat = RB + 1;
    gap = ST + 1;
    for (int b = 0; b < RB; b++) begin
      ones = 0;
      t    = 1'b0;
      for (int v = 0; v < V; v++) begin
        exp_chal.push_back(base + CW'(b));
        exp_gap.push_back(gap);
        // done_s is seen K+2 WAIT cycles after launch (model delay + sync).
        if (tab_tmo[b][v]) begin
          t  = 1'b1;
          vl = ST + TO + 2;
        end else begin
          ones += int'(tab_val[b][v]);
          vl = ST + 1 + (K + 2) + 1;
        end
        e.lat += vl;
        gap = vl + ((v == V - 1) ? 1 : 0);
      end
      e.resp[b]     = (ones > V / 2);
      e.unstable[b] = ((ones != 0) && (ones != V)) || t;
      e.tmo         = e.tmo | t;
    end
    exp_run.push_back(e);
  endtask

  task automatic do_start(input logic [CW-1:0] base);
    @(posedge clk); #1;
    chal_base = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i;
    i = 0;
    while (!resp_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_completed"}, 32'(resp_valid), 32'd1);
  endtask

  initial begin
    int v0;
    reset     = 1'b1;
    start     = 1'b0;
    chal_base = '0;
    for (int b = 0; b < RB; b++) set_bit(b, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_launch", 32'(launch), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_unstable", 32'(unstable), 32'd0);
    check("rst_chal_out", chal_out, 32'd0);
    check("rst_arb_reset", 32'(arb_reset), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Stable response, with stray start pulses while busy.
    set_bit(0, 1'b1, 1'b1, 1'b1, 1'b0);
    set_bit(1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_bit(2, 1'b1, 1'b1, 1'b1, 1'b0);
    set_bit(3, 1'b0, 1'b0, 1'b0, 1'b0);
    v0 = n_valid;
    push_expect(32'h1000_0000);
    do_start(32'h1000_0000);
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid("stable", 300);
    // Start presented in the DONE cycle must be ignored.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("done_start_ignored_busy", 32'(busy), 32'd0);
    check("resp_valid_one_cycle", 32'(resp_valid), 32'd0);
    check("stable_single_pulse", 32'(n_valid - v0), 32'd1);
    repeat (4) @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);

    // Majority voting.
    set_bit(0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_bit(1, 1'b1, 1'b0, 1'b1, 1'b0);
    set_bit(2, 1'b0, 1'b0, 1'b1, 1'b0);
    set_bit(3, 1'b0, 1'b0, 1'b0, 1'b0);
    push_expect(32'h0000_0055);
    do_start(32'h0000_0055);
    wait_valid("majority", 300);
    repeat (10) @(negedge clk);
    check("hold_resp", 32'(resp), 32'h2);
    check("hold_unstable", 32'(unstable), 32'h6);
    check("hold_timeout_err", 32'(timeout_err), 32'd0);
    check("hold_chal_out", chal_out, 32'h0000_0058);

    // Timed-out last vote on bit 3, challenge wrapping past 2^32.
    set_bit(0, 1'b1, 1'b1, 1'b1, 1'b0);
    set_bit(1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_bit(2, 1'b1, 1'b1, 1'b1, 1'b0);
    set_bit(3, 1'b1, 1'b0, 1'b0, 1'b1);
    push_expect(32'hFFFF_FFFE);
    do_start(32'hFFFF_FFFE);
    wait_valid("timeout", 400);
    repeat (3) @(negedge clk);
    check("tmo_hold_err", 32'(timeout_err), 32'd1);
    check("tmo_final_chal", chal_out, 32'h0000_0001);

    // Reset in the middle of bit 2's WAIT aborts without a result.
    set_bit(3, 1'b0, 1'b0, 1'b0, 1'b0);
    push_expect(32'h0000_0007);
    do_start(32'h0000_0007);
    begin
      int i;
      i = 0;
      while (m_launches < 2 * V + 1 && i < 300) begin
        @(negedge clk);
        i++;
      end
      check("reached_bit2_wait", 32'(m_launches), 32'(2 * V + 1));
    end
    v0 = n_valid;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_arb_reset", 32'(arb_reset), 32'd1);
    check("abort_resp", 32'(resp), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_launch", 32'(launch), 32'd0);
    repeat (150) @(negedge clk);
    check("abort_no_valid", 32'(n_valid - v0), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // Fresh run after the abort.
    push_expect(32'hA5A5_0000);
    do_start(32'hA5A5_0000);
    wait_valid("after_reset", 300);
    @(negedge clk);
    check("after_reset_single_pulse", 32'(n_valid - v0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
